mult_job_scheduler: RTL and testbench

- Upstream issue stage for the sequential shift-add multiplier (start / word0 / word1 / ready / product interface).
- Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO.
- Issues each job to the multiplier, clearing its accumulator first, and returns each product on a valid/ready output stream.
- Results leave in input order; a sticky error flag reports a multiplier that never completes.

---
 rtl/mult_job_scheduler_pkg.sv | 24 ++
 rtl/mult_job_scheduler_sync_fifo.sv | 71 +++++++
 rtl/mult_job_scheduler.sv | 163 ++++++++++++++++
 tb/tb_mult_job_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_job_scheduler_pkg.sv
// +----------------------------------------------------------------------+
// | mult_job_scheduler_pkg : shared state encoding and constants          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package mult_job_scheduler_pkg;

  localparam int DEFAULT_WORD_LENGTH = 4;

  // Fill bit replicated across the product width to form the timeout result.
  localparam logic TIMEOUT_FILL = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    LOAD  = 3'd2,
    WAIT  = 3'd3,
    OUT   = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mult_job_scheduler_sync_fifo.sv
// +----------------------------------------------------------------------+
// | sync_fifo : count-based synchronous FIFO, first-word-fall-through     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CNTW'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNTW'(do_push) - CNTW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_job_scheduler.sv
// +----------------------------------------------------------------------+
// | mult_job_scheduler : queues operand pairs and issues them in order to |
// | a sequential shift-add multiplier. Revision: 1.0                      |
// +----------------------------------------------------------------------+
`default_nettype none

module mult_job_scheduler
  import mult_job_scheduler_pkg::*;
#(
  parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = WORD_LENGTH + 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_LENGTH-1:0]   in_a,
  input  logic [WORD_LENGTH-1:0]   in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WORD_LENGTH-1:0] out_product,
  output logic                     mult_start,
  output logic [WORD_LENGTH-1:0]   mult_word0,
  output logic [WORD_LENGTH-1:0]   mult_word1,
  input  logic                     mult_ready,
  input  logic [2*WORD_LENGTH-1:0] mult_product,
  output logic                     busy,
  output logic                     err
);

  localparam int PW = 2 * WORD_LENGTH;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

  state_e                 state_q, state_d;
  logic [WORD_LENGTH-1:0] job_a_q, job_a_d;
  logic [WORD_LENGTH-1:0] job_b_q, job_b_d;
  logic [PW-1:0]          out_product_q, out_product_d;
  logic                   out_valid_q, out_valid_d;
  logic                   err_q, err_d;
  logic [CW-1:0]          tcnt_q, tcnt_d;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [PW-1:0]          fifo_rdata;

  sync_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_valid && in_ready),
    .push_data ({in_a, in_b}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready    = !fifo_full;
  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;
  assign err         = err_q;
  assign busy        = (state_q != IDLE) || !fifo_empty;

  always_comb begin
    state_d       = state_q;
    job_a_d       = job_a_q;
    job_b_d       = job_b_q;
    out_product_d = out_product_q;
    out_valid_d   = out_valid_q;
    err_d         = err_q;
    tcnt_d        = tcnt_q;
    fifo_pop      = 1'b0;
    mult_start    = 1'b0;
    mult_word0    = '0;
    mult_word1    = '0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop           = 1'b1;
          {job_a_d, job_b_d} = fifo_rdata;
          state_d            = FLUSH;
        end
      end

      // A start with both words zero clears the multiplier accumulator.
      FLUSH: begin
        if (mult_ready) begin
          mult_start = 1'b1;
          if ((job_a_q == '0) || (job_b_q == '0)) begin
            out_product_d = '0;
            out_valid_d   = 1'b1;
            state_d       = OUT;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        if (mult_ready) begin
          mult_start = 1'b1;
          mult_word0 = job_a_q;
          mult_word1 = job_b_q;
          tcnt_d     = '0;
          state_d    = WAIT;
        end
      end

      // Ready is still high on the first WAIT cycle; the multiplier drops it a cycle late.
      WAIT: begin
        tcnt_d = tcnt_q + 1'b1;
        if ((tcnt_q != '0) && mult_ready) begin
          out_product_d = mult_product;
          out_valid_d   = 1'b1;
          state_d       = OUT;
        end else if (tcnt_d == TIMEOUT_CNT) begin
          err_d         = 1'b1;
          out_product_d = {PW{TIMEOUT_FILL}};
          out_valid_d   = 1'b1;
          state_d       = OUT;
        end
      end

      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      job_a_q       <= '0;
      job_b_q       <= '0;
      out_product_q <= '0;
      out_valid_q   <= 1'b0;
      err_q         <= 1'b0;
      tcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      job_a_q       <= job_a_d;
      job_b_q       <= job_b_d;
      out_product_q <= out_product_d;
      out_valid_q   <= out_valid_d;
      err_q         <= err_d;
      tcnt_q        <= tcnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_job_scheduler.sv
// +----------------------------------------------------------------------+
// | tb_mult_job_scheduler : self-checking bench with a shift-add          |
// | multiplier model and an in-order result scoreboard. Revision: 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mult_job_scheduler;

  localparam int WL = 4;
  localparam int TO = WL + 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [WL-1:0] in_a;
  logic [WL-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [2*WL-1:0] out_product;
  logic          mult_start;
  logic [WL-1:0] mult_word0;
  logic [WL-1:0] mult_word1;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  // Multiplier model: zero/zero start clears the accumulator, otherwise it
  // adds a<<i for each set bit of b into the accumulator over WL cycles.
  logic          m_ready = 1'b1;
  logic [2*WL-1:0] m_acc = '0;
  logic [WL-1:0] m_a = '0;
  logic [WL-1:0] m_b = '0;
  int            m_phase = 0;
  int            m_step = 0;
  logic          stub_mode = 1'b0;

  mult_job_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_product  (out_product),
    .mult_start   (mult_start),
    .mult_word0   (mult_word0),
    .mult_word1   (mult_word1),
    .mult_ready   (m_ready),
    .mult_product (m_acc),
    .busy         (busy),
    .err          (err)
  );

  always @(posedge clk) begin
    case (m_phase)
      0: if (mult_start) begin
        if (mult_word0 == '0 && mult_word1 == '0) m_acc <= '0;
        else begin
          m_a <= mult_word0;
          m_b <= mult_word1;
          m_phase <= 1;
        end
      end
      1: begin
        m_ready <= 1'b0;
        m_step  <= 0;
        m_phase <= 2;
      end
      2: begin
        if (m_b[m_step]) m_acc <= m_acc + ((2*WL)'(m_a) << m_step);
        if (m_step == WL - 1) begin
          if (stub_mode) m_phase <= 3;
          else begin
            m_ready <= 1'b1;
            m_phase <= 0;
          end
        end else m_step <= m_step + 1;
      end
      default: if (!stub_mode) begin
        m_ready <= 1'b1;
        m_phase <= 0;
      end
    endcase
  end

  // Observation: cycle counter, received results, strobe and latency records.
  int            cyc = 0;
  logic [2*WL-1:0] rx_arr [0:255];
  int            rx_n = 0;
  int            flush_n = 0, load_n = 0, flush_cyc = 0, load_cyc = 0;
  int            valid_cyc = 0, vcycles = 0, viol_n = 0;
  logic          pv = 1'b0, pacc = 1'b0;
  logic [2*WL-1:0] pprod = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    pv    <= out_valid;
    pacc  <= out_valid && out_ready;
    pprod <= out_product;
    if (out_valid && out_ready) begin
      rx_arr[rx_n[7:0]] <= out_product;
      rx_n <= rx_n + 1;
    end
    if (out_valid) vcycles <= vcycles + 1;
    if (out_valid && !pv) valid_cyc <= cyc;
    if (pv && !pacc && !reset && (!out_valid || out_product != pprod)) viol_n <= viol_n + 1;
    if (mult_start) begin
      if (mult_word0 == '0 && mult_word1 == '0) begin
        flush_n   <= flush_n + 1;
        flush_cyc <= cyc;
      end else begin
        load_n   <= load_n + 1;
        load_cyc <= cyc;
      end
    end
  end

  int            tests = 0, fails = 0;
  logic [2*WL-1:0] exp_arr [0:255];
  int            exp_n = 0, chk_n = 0, push_cyc = 0;

  typedef struct {
    logic [WL-1:0]   a;
    logic [WL-1:0]   b;
    logic [2*WL-1:0] prod;
    int              loads;
  } vec_t;
  vec_t vecs [8];

  function automatic logic [2*WL-1:0] model(input logic [WL-1:0] a, input logic [WL-1:0] b,
                                           input bit stuck);
    return stuck ? {(2*WL){1'b1}} : (2*WL)'(a) * (2*WL)'(b);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [WL-1:0] a, input logic [WL-1:0] b, input logic [2*WL-1:0] e);
    int w = 0;
    @(posedge clk); #1;
    in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("send_accept", 0, 1);
    else begin
      exp_arr[exp_n[7:0]] = e;
      exp_n++;
      push_cyc = cyc;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_rx(input int target);
    int w = 0;
    while (rx_n < target && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (rx_n < target) check("result_timeout", rx_n, target);
  endtask

  task automatic compare_rx();
    while (chk_n < rx_n) begin
      check($sformatf("result%0d", chk_n), rx_arr[chk_n[7:0]], exp_arr[chk_n[7:0]]);
      chk_n++;
    end
  endtask

  initial begin
    int f0, l0, v0, r0, acc, sent, w;
    bit acc_flag;

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_product", out_product, 0);
    check("rst_mult_start", mult_start, 0);
    reset = 1'b0;

    vecs[0] = '{4'd3,  4'd5,  8'd15,  1};
    vecs[1] = '{4'd15, 4'd15, 8'd225, 1};
    vecs[2] = '{4'd1,  4'd1,  8'd1,   1};
    vecs[3] = '{4'd0,  4'd9,  8'd0,   0};
    vecs[4] = '{4'd9,  4'd0,  8'd0,   0};
    vecs[5] = '{4'd7,  4'd6,  8'd42,  1};
    vecs[6] = '{4'd15, 4'd1,  8'd15,  1};
    vecs[7] = '{4'd2,  4'd8,  8'd16,  1};

    v0 = vcycles;
    for (int i = 0; i < 8; i++) begin
      f0 = flush_n; l0 = load_n;
      send(vecs[i].a, vecs[i].b, model(vecs[i].a, vecs[i].b, 0));
      wait_rx(exp_n);
      check($sformatf("vec%0d_product", i), rx_arr[(exp_n - 1) & 255], vecs[i].prod);
      check($sformatf("vec%0d_flushes", i), flush_n - f0, 1);
      check($sformatf("vec%0d_loads", i), load_n - l0, vecs[i].loads);
      if (i == 0) begin
        check("lat_flush", flush_cyc - push_cyc, 2);
        check("lat_load", load_cyc - push_cyc, 3);
        check("lat_result", valid_cyc - load_cyc, WL + 3);
      end
      if (i == 3) check("lat_zero", valid_cyc - push_cyc, 3);
      compare_rx();
      repeat (2) @(posedge clk);
    end
    #1;
    check("valid_pulse_cycles", vcycles - v0, 8);

    // Backpressure: one job in service plus FIFO_DEPTH queued.
    out_ready = 1'b0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      in_a = 4'd2; in_b = 4'(i + 2); in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        exp_arr[exp_n[7:0]] = model(4'd2, 4'(i + 2), 0);
        exp_n++;
        acc++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_accepted", acc, 5);
    w = 0;
    while (!out_valid && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("bp_in_ready", in_ready, 0);
    check("bp_busy", busy, 1);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_product", out_product, 4);
    out_ready = 1'b1;
    wait_rx(exp_n);
    compare_rx();

    // Randomized jobs with random consumer backpressure.
    sent = 0; acc_flag = 0;
    for (int c = 0; c < 2000 && (sent < 20 || in_valid); c++) begin
      @(posedge clk); #1;
      if (acc_flag) begin
        in_valid = 1'b0;
        acc_flag = 0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < 20 && $urandom_range(0, 2) != 0) begin
        in_a = 4'($urandom); in_b = 4'($urandom); in_valid = 1'b1;
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_arr[exp_n[7:0]] = model(in_a, in_b, 0);
        exp_n++;
        sent++;
        acc_flag = 1;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    check("rand_sent", sent, 20);
    wait_rx(exp_n);
    compare_rx();

    // Stuck multiplier: timeout result, then err persists over a good job.
    stub_mode = 1'b1;
    send(4'd5, 4'd3, model(4'd5, 4'd3, 1));
    wait_rx(exp_n);
    compare_rx();
    check("timeout_latency", valid_cyc - load_cyc, TO + 1);
    check("timeout_err", err, 1);
    stub_mode = 1'b0;
    send(4'd2, 4'd3, model(4'd2, 4'd3, 0));
    wait_rx(exp_n);
    compare_rx();
    check("err_sticky", err, 1);

    // Reset while the job is in WAIT drops it.
    r0 = rx_n; l0 = load_n;
    send(4'd7, 4'd5, model(4'd7, 4'd5, 0));
    w = 0;
    while (load_n == l0 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst2_out_valid", out_valid, 0);
    check("rst2_in_ready", in_ready, 1);
    check("rst2_busy", busy, 0);
    check("rst2_err", err, 0);
    exp_n = r0; chk_n = r0;
    repeat (12) @(posedge clk);
    #1;
    check("rst2_no_result", rx_n, r0);
    send(4'd2, 4'd7, model(4'd2, 4'd7, 0));
    wait_rx(exp_n);
    compare_rx();
    check("rst2_final_product", rx_arr[(exp_n - 1) & 255], 14);

    check("output_hold_violations", viol_n, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
